// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Turns a raster-order pixel stream into 3x3 neighbourhoods for the filter region.
// Two line buffers hold rows r-1 and r-2. A 3x3 shift window advances one column per
// accepted pixel. The centre tap is kept internally because it feeds the left column
// of the middle row, but it is not driven out.
// While the region is blocked nothing is accepted and all stream state holds.

module window_3x3_gen #(
  parameter int PIX_W = 12,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             block,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Position counters: position of the next pixel to be accepted.
  logic [COL_W-1:0] col_reg;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_reg;
  logic [ROW_W-1:0] row_next;

  // Effective position of the pixel on pix_in this cycle. frame_start forces
  // (0,0) so a pixel arriving together with frame_start is taken as the origin.
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             col_last;
  logic             row_last;
  logic             accept;

  // Line buffer read data for the current column.
  logic [IMG_W-1:0][PIX_W-1:0] lb1_rd;
  logic [IMG_W-1:0][PIX_W-1:0] lb2_rd;
  logic [PIX_W-1:0]            lb1_col;
  logic [PIX_W-1:0]            lb2_col;

  // 3x3 window: win_reg[row][col], row 0 = r-2, row 2 = r; col 2 = newest column.
  logic [PIX_W-1:0] win_reg [3][3];

  logic win_valid_reg;
  logic win_valid_next;
  logic frame_done_reg;
  logic frame_done_next;

  assign pix_ready = ~block;
  assign accept    = pix_valid & ~block;

  assign cur_col  = frame_start ? '0 : col_reg;
  assign cur_row  = frame_start ? '0 : row_reg;
  assign col_last = (cur_col == COL_LAST);
  assign row_last = (cur_row == ROW_LAST);

  // Next-position logic: advance on accept, wrap at line and frame ends.
  // frame_start alone (no accept) still rewinds to the origin, even when blocked,
  // so a start pulse issued during a stall is not lost.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : cur_row + 1'b1;
      end else begin
        col_next = cur_col + 1'b1;
        row_next = cur_row;
      end
    end else if (frame_start) begin
      col_next = '0;
      row_next = '0;
    end
  end

  // Window and frame-end flags are computed from the pixel being accepted now
  // and registered, giving exactly one cycle of latency.
  always_comb begin
    win_valid_next  = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    frame_done_next = accept && col_last && row_last;
  end

  // Position counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // One storage column per image column. On accept the old row r-1 value moves
  // down to the r-2 buffer and the incoming pixel becomes the new r-1 value.
  generate
    for (genvar gi = 0; gi < IMG_W; gi++) begin : g_linebuf
      logic [PIX_W-1:0] lb1_reg;
      logic [PIX_W-1:0] lb2_reg;
      logic             col_hit;

      assign col_hit = accept && (cur_col == COL_W'(gi));

      // Per-column line buffer update.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lb1_reg <= '0;
          lb2_reg <= '0;
        end else if (col_hit) begin
          lb2_reg <= lb1_reg;
          lb1_reg <= pix_in;
        end
      end

      assign lb1_rd[gi] = lb1_reg;
      assign lb2_rd[gi] = lb2_reg;
    end
  endgenerate

  assign lb1_col = lb1_rd[cur_col];
  assign lb2_col = lb2_rd[cur_col];

  // Shift the window left one column per accepted pixel and load the new right
  // column from the line buffers (rows r-2, r-1) and the incoming pixel (row r).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= win_reg[r][2];
      end
      win_reg[0][2] <= lb2_col;
      win_reg[1][2] <= lb1_col;
      win_reg[2][2] <= pix_in;
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      win_valid_reg  <= win_valid_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign p0 = win_reg[0][0];
  assign p1 = win_reg[0][1];
  assign p2 = win_reg[0][2];
  assign p3 = win_reg[1][0];
  assign p5 = win_reg[1][2];
  assign p6 = win_reg[2][0];
  assign p7 = win_reg[2][1];
  assign p8 = win_reg[2][2];

  assign win_valid  = win_valid_reg;
  assign frame_done = frame_done_reg;

endmodule
